op_share_ctrl: RTL and testbench

Arbiter and sequencer that shares one small combinational functional unit among `NREQ` requesters. The unit performs XOR, increment, bitwise invert and equality compare. Each requester submits an opcode and two operands over a valid/ready handshake. The controller grants requesters round-robin, runs the unit for one granted request at a time, and returns a tagged result on a single valid/ready response port.

---
 rtl/op_share_pkg.sv | 8 +
 rtl/op_share_alu.sv | 25 ++
 rtl/op_share_ctrl.sv | 130 +++++++++++++
 tb/tb_op_share_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_share_pkg.sv
// Shared types for the operator-sharing controller and its functional unit.
package op_share_pkg;

  typedef enum logic [1:0] {OP_XOR, OP_INC, OP_INV, OP_CMP} op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

endpackage

// File: rtl/op_share_alu.sv
// Shared combinational functional unit: xor, increment, invert, equality.
module op_share_alu
  import op_share_pkg::*;
#(
  parameter int W = 8
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // Select the operation; increment wraps naturally at the W-bit boundary.
  always_comb begin
    y = '0;
    case (op)
      OP_XOR:  y = a ^ b;
      OP_INC:  y = a + {{(W-1){1'b0}}, 1'b1};
      OP_INV:  y = ~a;
      OP_CMP:  y = {{(W-1){1'b0}}, (a == b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/op_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one op_share_alu among NREQ requesters.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for a valid requester; grant the round-robin winner
//   ST_EXEC | captured request is evaluated, response registers loaded
//   ST_RESP | response held on rsp_* until rsp_ready is sampled high
module op_share_ctrl
  import op_share_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0][1:0]   req_op,
  input  logic [NREQ-1:0][W-1:0] req_a,
  input  logic [NREQ-1:0][W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [W-1:0]           rsp_data,
  output logic [IW-1:0]          rsp_id
);

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] rr_next;
  logic          grant_any;
  logic          accept;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  op_e           op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [IW-1:0] id_q;
  logic [W-1:0]  alu_y;

  logic          rsp_valid_q;
  logic [W-1:0]  rsp_data_q;
  logic [IW-1:0] rsp_id_q;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping mod NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr_q;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign accept  = (state_q == ST_IDLE) && grant_any;
  assign rr_next = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + IW'(1);

  // Grant is combinational on req_valid; held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[grant_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_any) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture on grant, response load in EXEC, release on downstream accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      op_q        <= OP_XOR;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q <= rr_next;
        op_q     <= op_e'(req_op[grant_idx]);
        a_q      <= req_a[grant_idx];
        b_q      <= req_b[grant_idx];
        id_q     <= grant_idx;
      end
      if (state_q == ST_EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= alu_y;
        rsp_id_q    <= id_q;
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  op_share_alu #(.W(W)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_op_share_ctrl.sv
// Bench for op_share_ctrl: vector table, directed corner sequences, random traffic
// checked every cycle against a transaction-level reference model.
module tb_op_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IW   = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][1:0]   req_op;
  logic [NREQ-1:0][W-1:0] req_a;
  logic [NREQ-1:0][W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [W-1:0]           rsp_data;
  logic [IW-1:0]          rsp_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  op_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  function automatic logic [IW-1:0] ix(input int i);
    return IW'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int unsigned s;
    case (op)
      2'd0:    return a ^ b;
      2'd1:    begin s = (int'(a) + 1) % (1 << W); return W'(s); end
      2'd2:    return ~a;
      default: return (a == b) ? W'(1) : W'(0);
    endcase
  endfunction

  // Transaction-level model: one job outstanding at a time, response visible from the
  // second edge after acceptance, grants only when no job is outstanding.
  bit           m_busy;
  int           m_age;
  int           m_rr;
  int           m_id;
  logic [W-1:0] m_data;

  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] exp_ready;
    int              pick;
    bit              exp_rv;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_rr   = 0;
    end else begin
      exp_ready = '0;
      pick      = -1;
      if (!m_busy)
        for (int k = 0; k < NREQ; k++)
          if (pick < 0 && req_valid[ix((m_rr + k) % NREQ)]) pick = (m_rr + k) % NREQ;
      if (pick >= 0) exp_ready[ix(pick)] = 1'b1;
      check("grant", 32'(req_ready), 32'(exp_ready));
      exp_rv = m_busy && (m_age >= 1);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        check("rsp_data", 32'(rsp_data), 32'(m_data));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
      end
      if (m_busy) begin
        if (exp_rv && rsp_ready) m_busy = 1'b0;
        else                     m_age++;
      end else if (pick >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_id   = pick;
        m_data = ref_result(req_op[ix(pick)], req_a[ix(pick)], req_b[ix(pick)]);
        m_rr   = (pick + 1) % NREQ;
      end
    end
  end

  typedef struct {
    int           idx;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_op[ix(i)]    = op;
    req_a[ix(i)]     = a;
    req_b[ix(i)]     = b;
    req_valid[ix(i)] = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    bit ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[ix(i)]) ok = 1'b1;
    end
    check("grant timeout", 32'(ok), 32'(1));
  endtask

  task automatic wait_rsp();
    bit ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    check("rsp timeout", 32'(ok), 32'(1));
  endtask

  task automatic run_one(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] data,
                         output logic [IW-1:0] id);
    @(posedge clk); #1;
    set_req(i, op, a, b);
    wait_grant(i);
    @(posedge clk); #1;
    req_valid[ix(i)] = 1'b0;
    wait_rsp();
    data = rsp_data;
    id   = rsp_id;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]    d;
    logic [IW-1:0]   id;
    logic [NREQ-1:0] acc;
    int              gq[$];
    int              rq[$];

    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;

    vecs[0] = '{0, 2'b01, 8'hFF, 8'h00, 8'h00};
    vecs[1] = '{1, 2'b11, 8'h3C, 8'h3C, 8'h01};
    vecs[2] = '{3, 2'b11, 8'h3C, 8'h3D, 8'h00};
    vecs[3] = '{2, 2'b10, 8'h5A, 8'h77, 8'hA5};
    vecs[4] = '{1, 2'b01, 8'h7F, 8'h00, 8'h80};
    vecs[5] = '{3, 2'b00, 8'h00, 8'hFF, 8'hFF};
    vecs[6] = '{0, 2'b00, 8'hC3, 8'hC3, 8'h00};

    // Reset values, including grant suppression while reset is held.
    #2;
    check("rst req_ready", 32'(req_ready), 32'(0));
    check("rst rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst rsp_data", 32'(rsp_data), 32'(0));
    check("rst rsp_id", 32'(rsp_id), 32'(0));
    req_valid = '1;
    #1;
    check("rst req_ready gated", 32'(req_ready), 32'(0));
    req_valid = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single XOR from requester 2 with rsp_ready held high.
    @(posedge clk); #1;
    set_req(2, 2'b00, 8'hA5, 8'h0F);
    wait_grant(2);
    check("t1 grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("t1 ready pulse", 32'(req_ready), 32'(0));
    check("t1 exec no rsp", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    check("t1 rsp_valid", 32'(rsp_valid), 32'(1));
    check("t1 rsp_data", 32'(rsp_data), 32'(8'hAA));
    check("t1 rsp_id", 32'(rsp_id), 32'(2));
    @(negedge clk);
    check("t1 rsp one cycle", 32'(rsp_valid), 32'(0));

    // Opcode vector table.
    foreach (vecs[v]) begin
      run_one(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b, d, id);
      check($sformatf("vec%0d data", v), 32'(d), 32'(vecs[v].exp));
      check($sformatf("vec%0d id", v), 32'(id), 32'(vecs[v].idx));
    end

    // All requesters continuously valid: strict rotation from 0.
    reset_dut();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    for (int c = 0; c < 80 && rq.size() < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("rr onehot", 32'($countones(req_ready)), 32'(1));
        for (int i = 0; i < NREQ; i++) if (req_ready[ix(i)]) gq.push_back(i);
      end
      if (rsp_valid && rsp_ready) rq.push_back(int'(rsp_id));
    end
    check("rr rsp count", 32'(rq.size()), 32'(8));
    for (int k = 0; k < 8 && k < gq.size() && k < rq.size(); k++) begin
      check($sformatf("rr grant%0d", k), 32'(gq[k]), 32'(k % NREQ));
      check($sformatf("rr rsp_id%0d", k), 32'(rq[k]), 32'(k % NREQ));
    end
    drain();

    // Back-pressure: response held for 5 cycles, then next grant follows rr_ptr.
    reset_dut();
    rsp_ready = 1'b0;
    set_req(1, 2'b10, 8'h12, 8'h00);
    wait_grant(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(0, 2'b00, 8'h11, 8'h22);
    set_req(3, 2'b01, 8'h41, 8'h00);
    wait_rsp();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp rsp_valid", 32'(rsp_valid), 32'(1));
      check("bp rsp_data", 32'(rsp_data), 32'(8'hED));
      check("bp rsp_id", 32'(rsp_id), 32'(1));
      check("bp no grant", 32'(req_ready), 32'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp release hold", 32'(rsp_valid), 32'(1));
    @(negedge clk);
    check("bp next grant", 32'(req_ready), 32'(4'b1000));
    drain();

    // Reset asserted during EXEC of an INV request.
    reset_dut();
    run_one(0, 2'b00, 8'h3C, 8'h00, d, id);
    @(posedge clk); #1;
    set_req(1, 2'b10, 8'h5A, 8'h00);
    wait_grant(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(3, 2'b00, 8'h0F, 8'hF0);
    set_req(2, 2'b01, 8'h20, 8'h00);
    rst_n = 1'b0;
    #1;
    check("arst req_ready", 32'(req_ready), 32'(0));
    check("arst rsp_valid", 32'(rsp_valid), 32'(0));
    check("arst rsp_data", 32'(rsp_data), 32'(0));
    check("arst rsp_id", 32'(rsp_id), 32'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst no stale rsp", 32'(rsp_valid), 32'(0));
    check("arst first grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_rsp();
    check("arst rsp_id", 32'(rsp_id), 32'(2));
    check("arst rsp_data", 32'(rsp_data), 32'(8'h21));
    drain();

    // Requester 1 withdraws before grant; only requester 3 is served, rr_ptr wraps to 0.
    reset_dut();
    rsp_ready = 1'b0;
    set_req(0, 2'b01, 8'h10, 8'h00);
    wait_grant(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, 2'b00, 8'h01, 8'h02);
    set_req(3, 2'b11, 8'h55, 8'h55);
    wait_rsp();
    check("drop first data", 32'(rsp_data), 32'(8'h11));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drop grant r3", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    set_req(0, 2'b10, 8'h00, 8'h00);
    set_req(1, 2'b10, 8'h01, 8'h00);
    wait_rsp();
    check("drop rsp_id", 32'(rsp_id), 32'(3));
    check("drop rsp_data", 32'(rsp_data), 32'(8'h01));
    @(negedge clk);
    check("drop rr wrap", 32'(req_ready), 32'(4'b0001));
    drain();

    // Random traffic against the reference model.
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[ix(i)]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
          else
            req_valid[ix(i)] = 1'b0;
        end else if (req_valid[ix(i)]) begin
          if ($urandom_range(0, 15) == 0) req_valid[ix(i)] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
